// File: rtl/fifo_wr_arb_if.sv
// Write-side arbiter bus: requester handshakes, FIFO write port and
// arbitration status, bundled so the arbiter and its environment share one
// declaration.
interface fifo_wr_arb_if #(
    parameter int unsigned DSIZE = 8,
    parameter int unsigned NREQ  = 4
);
    localparam int unsigned GW = $clog2(NREQ);

    // Requester side
    logic [NREQ-1:0]       req_valid;
    logic [NREQ-1:0]       req_last;
    logic [NREQ*DSIZE-1:0] req_data;
    logic [NREQ-1:0]       req_ready;

    // FIFO write port
    logic [DSIZE-1:0]      wdata;
    logic                  winc;
    logic                  wfull;

    // Arbitration status
    logic [GW-1:0]         grant_id;
    logic                  busy;

    // The arbiter
    modport slave (
        input  req_valid, req_last, req_data, wfull,
        output req_ready, wdata, winc, grant_id, busy
    );

    // Requesters plus FIFO, seen from outside the arbiter
    modport master (
        output req_valid, req_last, req_data, wfull,
        input  req_ready, wdata, winc, grant_id, busy
    );
endinterface

// File: rtl/fifo_wr_arb.sv
// Round-robin write-port arbiter for the async FIFO write side.
// A grant is held for a whole packet (up to MAXLEN beats, then forcibly
// released). The FIFO write enable is never raised while wfull is high.
module fifo_wr_arb #(
    parameter int unsigned DSIZE  = 8,
    parameter int unsigned NREQ   = 4,
    parameter int unsigned MAXLEN = 16
) (
    input  logic         wclk,
    input  logic         wrst_n,
    fifo_wr_arb_if.slave bus
);
    localparam int unsigned GW = $clog2(NREQ);
    // Beat count value at which the current beat is the last one allowed
    localparam logic [7:0] BCNT_LAST = 8'(MAXLEN - 1);

    typedef enum logic {
        IDLE = 1'b0,
        XFER = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [GW-1:0]   grant_id_q, grant_id_d;
    logic [GW-1:0]   last_gnt_q, last_gnt_d;
    logic [7:0]      bcnt_q, bcnt_d;

    logic            any_valid;
    logic [GW-1:0]   winner;
    logic            gnt_valid;
    logic            gnt_last;
    logic            beat;
    logic            rel;

    // State register: FSM state, grant owner, round-robin pointer, beat count
    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            state_q    <= IDLE;
            grant_id_q <= '0;
            last_gnt_q <= GW'(NREQ - 1);
            bcnt_q     <= '0;
        end else begin
            state_q    <= state_d;
            grant_id_q <= grant_id_d;
            last_gnt_q <= last_gnt_d;
            bcnt_q     <= bcnt_d;
        end
    end

    // Round-robin winner: first valid requester after last_gnt, wrapping mod NREQ
    always_comb begin
        logic [GW-1:0] idx;
        any_valid = 1'b0;
        winner    = '0;
        idx       = '0;
        for (int unsigned k = 1; k <= NREQ; k++) begin
            idx = GW'((32'(last_gnt_q) + k) % NREQ);
            if (!any_valid && bus.req_valid[idx]) begin
                any_valid = 1'b1;
                winner    = idx;
            end
        end
    end

    // Beat and release qualification for the current owner
    always_comb begin
        gnt_valid = bus.req_valid[grant_id_q];
        gnt_last  = bus.req_last[grant_id_q];
        beat      = (state_q == XFER) && gnt_valid && !bus.wfull;
        // last-beat and MAXLEN conditions together still give one release
        rel       = beat && (gnt_last || (bcnt_q == BCNT_LAST));
    end

    // Next-state logic: grant in IDLE, count beats and release in XFER
    always_comb begin
        state_d    = state_q;
        grant_id_d = grant_id_q;
        last_gnt_d = last_gnt_q;
        bcnt_d     = bcnt_q;
        case (state_q)
            IDLE: begin
                if (any_valid) begin
                    grant_id_d = winner;
                    bcnt_d     = '0;
                    state_d    = XFER;
                end
            end
            XFER: begin
                if (rel) begin
                    last_gnt_d = grant_id_q;
                    bcnt_d     = '0;
                    state_d    = IDLE;
                end else if (beat) begin
                    bcnt_d = bcnt_q + 8'd1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Output logic: FIFO write strobe, data mux and per-requester ready
    always_comb begin
        bus.winc      = beat;
        bus.wdata     = '0;
        bus.req_ready = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (grant_id_q == GW'(i)) begin
                bus.wdata        = bus.req_data[i*DSIZE +: DSIZE];
                bus.req_ready[i] = (state_q == XFER) && !bus.wfull;
            end
        end
    end

    assign bus.grant_id = grant_id_q;
    assign bus.busy     = (state_q == XFER);

    // Protocol invariants
    a_no_write_when_full: assert property (@(posedge wclk) disable iff (!wrst_n)
        !(bus.winc && bus.wfull));
    a_bcnt_bounded: assert property (@(posedge wclk) disable iff (!wrst_n)
        32'(bcnt_q) < MAXLEN);
    a_ready_onehot: assert property (@(posedge wclk) disable iff (!wrst_n)
        $onehot0(bus.req_ready));
endmodule
